serial_to_parallel_hs: RTL

//   Parametrised serial-in/parallel-out deserializer for the bit-serial adder datapath.
//   - Collects WIDTH qualified serial bits into a word, selectable LSB- or MSB-first.
//   - Presents each word on a valid/ready output register, with frame resync and a sticky overrun flag.
//   - Sits between the bit-serial adder's sum output and parallel consumers (display, register file).

---
 rtl/serial_to_parallel_hs.sv | 74 +++++++
 1 files changed

// File: rtl/serial_to_parallel_hs.sv
// Bit-serial to parallel deserializer with a valid/ready output holding register,
// frame resync and a sticky overrun flag.
module serial_to_parallel_hs #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in,
  input  logic                       in_valid,
  input  logic                       sync,
  output logic [WIDTH-1:0]           out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH)-1:0]   bit_cnt,
  output logic                       overrun,
  input  logic                       clr_ovr
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] shifted;
  logic             last;
  logic             complete;
  logic             load;
  logic             drop;

  // sync discards the partial word, so a bit arriving with it shifts into a cleared register
  always_comb begin
    base     = sync ? '0 : sreg;
    shifted  = LSB_FIRST ? {in, base[WIDTH-1:1]} : {base[WIDTH-2:0], in};
    last     = (bit_cnt == LAST_BIT);
    complete = in_valid & ~sync & last;
    load     = complete & (~out_valid | out_ready);
    drop     = complete & out_valid & ~out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg      <= '0;
      bit_cnt   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (in_valid)
        sreg <= shifted;
      else if (sync)
        sreg <= '0;

      if (sync)
        bit_cnt <= in_valid ? CW'(1) : '0;
      else if (in_valid)
        bit_cnt <= last ? '0 : bit_cnt + 1'b1;

      if (load) begin
        out       <= shifted;
        out_valid <= 1'b1;
      end else if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end

      // a fresh overrun takes priority over a clear in the same cycle
      if (drop)
        overrun <= 1'b1;
      else if (clr_ovr)
        overrun <= 1'b0;
    end
  end

endmodule
